// File: rtl/gate_truth_checker.sv
// Truth-table sweeper for an N_IN-input combinational gate: drives every input
// vector, holds it SETTLE+1 cycles, samples y_in on the last edge and scores it.
module gate_truth_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expect_tt,
  input  logic                   y_in,
  output logic [N_IN-1:0]        stim,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_cnt,
  output logic                   first_fail_valid,
  output logic [N_IN-1:0]        first_fail_vec
);

  localparam int V  = 1 << N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic            ff_valid;
    logic [N_IN-1:0] ff_vec;
  } result_t;

  state_e          state_q, state_d;
  logic [V-1:0]    tt_q, tt_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  result_t         res_q, res_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sample_last;

  // Final sample edge of a sweep: counter expired on the last vector.
  assign sample_last = (state_q == RUN) && (cnt_q == '0) && (stim_q == LAST_VEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tt_q    <= '0;
      stim_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (sample_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tt_d   = tt_q;
    stim_d = stim_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tt_d   = expect_tt;
          stim_d = '0;
          cnt_d  = CNT_LOAD;
          res_d  = '0;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (y_in != tt_q[stim_q]) begin
            res_d.err_cnt = res_q.err_cnt + (N_IN+1)'(1);
            if (!res_q.ff_valid) begin
              res_d.ff_valid = 1'b1;
              res_d.ff_vec   = stim_q;
            end
          end
          if (stim_q == LAST_VEC) begin
            busy_d     = 1'b0;
            done_d     = 1'b1;
            stim_d     = '0;
            res_d.pass = (res_d.err_cnt == '0);
          end else begin
            stim_d = stim_q + N_IN'(1);
            cnt_d  = CNT_LOAD;
          end
        end
      end
      default: ;
    endcase
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = res_q.pass;
  assign err_cnt          = res_q.err_cnt;
  assign first_fail_valid = res_q.ff_valid;
  assign first_fail_vec   = res_q.ff_vec;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (SETTLE=2 and SETTLE=0) share a
// gate model and are scored against a truth-table reference model.
module tb_gate_truth_checker;
  localparam int N = 2, V = 4, SA = 2, SB = 0;

  logic clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic [V-1:0] expect_tt = '0, gate_tt = '0;
  logic [N-1:0] stim_a, stim_b, ffvec_a, ffvec_b;
  logic [N:0]   err_a, err_b;
  logic y_a, y_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;
  int n_chk = 0, n_err = 0;

  assign y_a = gate_tt[stim_a];
  assign y_b = gate_tt[stim_b];

  always #5 clk = ~clk;

  gate_truth_checker #(.N_IN(N), .SETTLE(SA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expect_tt(expect_tt), .y_in(y_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));

  gate_truth_checker #(.N_IN(N), .SETTLE(SB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expect_tt(expect_tt), .y_in(y_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: score the gate's real table against the expected one, vector by vector.
  function automatic void model(input logic [V-1:0] e, input logic [V-1:0] g,
                                output int err, output int ffv, output int ffvec, output int ps);
    err = 0; ffv = 0; ffvec = 0;
    for (int v = 0; v < V; v++)
      if (e[v] != g[v]) begin
        if (err == 0) begin ffv = 1; ffvec = v; end
        err++;
      end
    ps = (err == 0);
  endfunction

  // Entered just after a negedge with both DUTs idle.
  task automatic sweep(input string tag, input logic [V-1:0] e, input logic [V-1:0] g,
                       input bit inj, input bit hold);
    int c, bsa, bsb, dna, dca, dcb, bad, err, ffv, ffvec, ps;
    bit seen;
    bsa = 0; bsb = 0; dna = 0; dca = -1; dcb = -1; bad = 0;
    model(e, g, err, ffv, ffvec, ps);
    expect_tt = e; gate_tt = g; start_a = 1'b1; start_b = 1'b1;
    @(negedge clk);
    if (!hold) start_a = 1'b0;
    start_b = 1'b0;
    expect_tt = $urandom;
    for (c = 1; c <= 40; c++) begin
      if (c == 1) chk({tag, "/cleared"}, {pass_a, err_a, ffv_a, ffvec_a}, 0);
      if (busy_a) begin
        if (int'(stim_a) != (c - 1) / (SA + 1)) bad++;
        bsa++;
      end
      if (busy_b) bsb++;
      if (done_b && dcb < 0) begin
        dcb = c;
        chk({tag, "/b_res"}, {pass_b, err_b, ffv_b, ffvec_b, stim_b}, {ps[0], err[N:0], ffv[0], ffvec[N-1:0], 2'b00});
      end
      if (done_a) begin
        dna++;
        if (dca < 0) begin
          dca = c;
          chk({tag, "/a_pass"}, pass_a, ps);
          chk({tag, "/a_err"}, err_a, err);
          chk({tag, "/a_ff"}, {ffv_a, ffvec_a}, {ffv[0], ffvec[N-1:0]});
          chk({tag, "/a_stim0"}, stim_a, 0);
        end
      end
      if (inj) start_a = (c == 5 || c == V * (SA + 1));
      if (c == V * (SA + 1)) expect_tt = e;
      if (dca >= 0 && (hold || c >= dca + 3)) break;
      @(negedge clk);
    end
    chk({tag, "/busy_a"}, bsa, V * (SA + 1));
    chk({tag, "/busy_b"}, bsb, V * (SB + 1));
    chk({tag, "/done_a_cyc"}, dca, V * (SA + 1) + 1);
    chk({tag, "/done_b_cyc"}, dcb, V * (SB + 1) + 1);
    chk({tag, "/stim_seq"}, bad, 0);
    if (!hold) begin
      chk({tag, "/done_once"}, dna, 1);
      chk({tag, "/idle_after"}, {busy_a, done_a}, 0);
    end else begin
      @(negedge clk);
      start_a = 1'b0;
      chk({tag, "/restart"}, {busy_a, stim_a, err_a, pass_a}, {1'b1, 2'b00, 3'b000, 1'b0});
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
        @(negedge clk);
        if (done_a) seen = 1'b1;
      end
      chk({tag, "/re_done"}, seen, 1);
      chk({tag, "/re_res"}, {pass_a, err_a, ffv_a, ffvec_a}, {ps[0], err[N:0], ffv[0], ffvec[N-1:0]});
      @(negedge clk);
    end
  endtask

  initial begin
    logic [V-1:0] e, g;
    bit hit;
    #2;
    chk("rst_a", {stim_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a}, 0);
    chk("rst_b", {stim_b, busy_b, done_b, pass_b, err_b, ffv_b, ffvec_b}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    sweep("or_ok",     4'b1110, 4'b1110, 1'b0, 1'b0);
    sweep("and_wrong", 4'b1110, 4'b1000, 1'b0, 1'b0);
    sweep("stuck1",    4'b1110, 4'b1111, 1'b0, 1'b0);
    sweep("or_again",  4'b1110, 4'b1110, 1'b0, 1'b0);
    sweep("all_bad",   4'b0000, 4'b1111, 1'b0, 1'b0);
    sweep("start_inj", 4'b1110, 4'b1110, 1'b1, 1'b0);
    sweep("start_hold",4'b1110, 4'b1000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a sweep.
    expect_tt = 4'b1110; gate_tt = 4'b1110; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (stim_a == 2'd2) hit = 1'b1;
      else @(negedge clk);
    end
    chk("mid_reach", hit, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", {stim_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    sweep("post_rst", 4'b1110, 4'b1110, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      e = V'($urandom);
      g = ($urandom_range(0, 3) == 0) ? e : (e ^ V'($urandom));
      sweep($sformatf("rnd%0d", i), e, g, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
